// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Holds the loader FSM state encoding and the stream word geometry.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream valid/ready channel feeding the program loader.
// master: byte source (drives in_data/in_valid); slave: loader (drives in_ready).
interface imem_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles big-endian 32-bit words from accepted stream bytes.
// Ports: clock/reset, accept_i + byte_i in; word_complete_o + word_o out.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        word_complete_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [23:0] shift_q;
    logic [23:0] shift_d;

    // The fourth byte is taken straight from the input, so the word is
    // complete in the same cycle its last byte is accepted.
    assign word_complete_o = accept_i && (cnt_q == LAST_BYTE);
    assign word_o          = {shift_q, byte_i};

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (accept_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a length-prefixed byte stream and writes instruction
// memory, holding the core in reset until the whole program is in place.
// Ports: clock/reset; stream (slave byte channel); mem_we/mem_addr/mem_wdata
// write port; cpu_reset, done, overflow, words_loaded status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    imem_loader_if.slave          stream,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           words_loaded
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    state_e                state_q;
    state_e                state_d;
    logic [15:0]           len_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  overflow_q;
    logic [15:0]           words_loaded_q;

    logic        in_ready;
    logic        accept;
    logic        data_accept;
    logic        word_complete;
    logic [31:0] word;
    logic [16:0] hdr_len;
    logic        word_in_range;
    logic        last_word;

    assign accept      = stream.in_valid && in_ready;
    assign data_accept = accept && (state_q == DATA);

    // Full header length, valid while the low byte is on the bus.
    assign hdr_len = {1'b0, len_q[15:8], stream.in_data};

    // words_loaded_q doubles as the index of the word being assembled.
    assign word_in_range = {1'b0, words_loaded_q} < DEPTH;
    assign last_word     = (words_loaded_q + 16'd1) == len_q;

    byte_word_packer u_packer (
        .clock           (clock),
        .reset           (reset),
        .accept_i        (data_accept),
        .byte_i          (stream.in_data),
        .word_complete_o (word_complete),
        .word_o          (word)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            LEN_HI: begin
                in_ready = 1'b1;
                if (accept) state_d = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (accept) state_d = (hdr_len == 17'd0) ? DONE : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                if (word_complete && last_word) state_d = FLUSH;
            end
            // Lets the final write commit before the core is released.
            FLUSH:   state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = LEN_HI;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LEN_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q          <= 16'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
            overflow_q     <= 1'b0;
            words_loaded_q <= 16'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (accept && state_q == LEN_HI) begin
                len_q[15:8] <= stream.in_data;
            end
            if (accept && state_q == LEN_LO) begin
                len_q[7:0] <= stream.in_data;
                if (hdr_len > DEPTH) overflow_q <= 1'b1;
            end
            if (word_complete) begin
                mem_wdata_q    <= word;
                mem_addr_q     <= words_loaded_q[ADDR_WIDTH-1:0];
                mem_we_q       <= word_in_range;
                words_loaded_q <= words_loaded_q + 16'd1;
            end
        end
    end

    assign stream.in_ready = in_ready;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign cpu_reset       = (state_q != DONE);
    assign done            = (state_q == DONE);
    assign overflow        = overflow_q;
    assign words_loaded    = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Uses a 4-word memory so the overflow path is reachable.
module tb_imem_loader;

    localparam int AW = 2;

    logic          clock;
    logic          reset;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          overflow;
    logic [15:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [33:0] exp_q[$];
    logic        prev_we;

    imem_loader_if bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .stream       (bus.slave),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .overflow     (overflow),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {30'd0, mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("write", {30'd0, mem_addr, mem_wdata}, {30'd0, exp_q.pop_front()});
                end
                if (prev_we) chk("we_twice", 64'd1, 64'd0);
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!acc && t < 50) begin
            @(negedge clock);
            acc = bus.in_ready;
            @(posedge clock);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_word(input int idx, input logic [31:0] w,
                             input bit gaps);
        if (idx < (1 << AW)) exp_q.push_back({2'(idx), w});
        for (int i = 3; i >= 0; i--) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send(tmp[7:0]);
            if (gaps) idle(1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd1);
        chk({tag, "_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_addr"}, {62'd0, mem_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
        chk({tag, "_words"}, {48'd0, words_loaded}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic basic_load(input bit gaps, input string tag);
        send(8'h00);
        send(8'h02);
        send_word(0, 32'h2008_0005, gaps);
        send_word(1, 32'h0109_5020, gaps && 1'b0);
        chk({tag, "_cpu_reset_hold"}, {63'd0, cpu_reset}, 64'd1);
        chk({tag, "_we_last"}, {63'd0, mem_we}, 64'd1);
        idle(1);
        chk({tag, "_cpu_reset_rel"}, {63'd0, cpu_reset}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_words"}, {48'd0, words_loaded}, 64'd2);
        chk({tag, "_ready_off"}, {63'd0, bus.in_ready}, 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        prev_we      = 1'b0;
        #12;
        check_reset_vals("init");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Full-rate two-word load.
        basic_load(1'b0, "full");
        do_reset();

        // Same stream with idle cycles between bytes.
        basic_load(1'b1, "gaps");
        do_reset();

        // Empty program.
        send(8'h00);
        send(8'h00);
        chk("n0_done", {63'd0, done}, 64'd1);
        chk("n0_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        chk("n0_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("n0_words", {48'd0, words_loaded}, 64'd0);
        do_reset();

        // Header larger than the memory.
        send(8'h00);
        send(8'h05);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            send_word(i, 32'hA000_0000 + 32'(i), 1'b0);
        end
        chk("ovf_we_last", {63'd0, mem_we}, 64'd0);
        chk("ovf_addr_last", {62'd0, mem_addr}, 64'd0);
        idle(1);
        chk("ovf_words", {48'd0, words_loaded}, 64'd5);
        chk("ovf_done", {63'd0, done}, 64'd1);
        chk("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Reset in the middle of a three-word load.
        do_reset();
        send(8'h00);
        send(8'h03);
        send_word(0, 32'h1111_2222, 1'b0);
        send(8'h33);
        send(8'h44);
        do_reset();

        // Restart with a one-word program.
        send(8'h00);
        send(8'h01);
        send_word(0, 32'hDEAD_BEEF, 1'b0);
        idle(1);
        chk("restart_done", {63'd0, done}, 64'd1);
        chk("restart_words", {48'd0, words_loaded}, 64'd1);

        // Bytes offered after completion are ignored.
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("done_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("done_words", {48'd0, words_loaded}, 64'd1);
        chk("done_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
        chk("done_addr", {62'd0, mem_addr}, 64'd0);
        chk("done_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        chk("done_flag", {63'd0, done}, 64'd1);

        chk("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes into the instruction memory the single-cycle core fetches from. It accepts a byte stream with a valid/ready handshake, assembles big-endian 32-bit instruction words and drives the instruction memory write port. It holds the core in reset until the whole program has been written, then releases it. It sits beside `instruction_memory` at top level. The loader `cpu_reset` output is ORed into the core's `reset`.

## Interface
- `ADDR_WIDTH`, default 8: instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers on an edge where `in_valid && in_ready`.
- `mem_we`  out  1  instruction memory write enable, one-cycle pulse per word.
- `mem_addr`  out  ADDR_WIDTH  word index; the memory's byte address is `mem_addr << 2`.
- `mem_wdata`  out  32  instruction word.
- `cpu_reset`  out  1  high while loading; holds the core's PC in reset.
- `done`  out  1  load complete; sticky until `reset`.
- `overflow`  out  1  header length exceeded memory depth; sticky until `reset`.
- `words_loaded`  out  16  count of words received.

## Operation
- Stream format:
  - 2-byte header: word count N, big-endian, high byte first.
  - Then N×4 data bytes; each word is sent most-significant byte first.
- States:
  - LEN_HI: accept header byte 0 → LEN_LO.
  - LEN_LO: accept header byte 1.
    - N=0 → DONE.
    - N>0 → DATA.
    - Set `overflow` if N > 2^ADDR_WIDTH.
  - DATA: accept bytes.
    - A 2-bit byte counter counts 0..3.
    - A 24-bit shift register holds the earlier bytes of the word.
  - FLUSH: one cycle; no bytes accepted; → DONE.
  - DONE: idle until `reset`.
- `in_ready` is combinational from state: 1 in LEN_HI, LEN_LO and DATA; 0 in FLUSH and DONE.
- Word completion, on the edge accepting byte 3 of word i:
  - `mem_wdata` ← {shift[23:0], `in_data`}.
  - `mem_addr` ← i[ADDR_WIDTH-1:0].
  - `mem_we` ← 1, unless i ≥ 2^ADDR_WIDTH; overflow words are consumed but not written.
  - `words_loaded` ← i+1.
  - If i = N−1, → FLUSH; otherwise stay in DATA.
- `mem_we` falls on the next edge; it is never high for two consecutive cycles.
- `cpu_reset` = 0 and `done` = 1 only in DONE.
- Gaps in `in_valid` stall the FSM with no effect on partial word state.
- Bytes presented in FLUSH or DONE are not accepted.

## Timing
- Reset values (asynchronous):
  - state = LEN_HI, so `in_ready` = 1.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_reset` = 1, `done` = 0, `overflow` = 0, `words_loaded` = 0.
  - Byte counter and shift register cleared.
- Throughput: one byte per cycle; one word per 4 cycles at full rate.
- Write latency: `mem_we` is high for the cycle after the 4th byte is accepted; the memory commits on the following edge.
- Release:
  - N>0: `cpu_reset` falls on the edge that commits the final word (edge k+1 when the final byte is accepted at edge k); `done` rises on that same edge.
  - N=0: `cpu_reset` falls on the LEN_LO acceptance edge.
  - In both cases the core's first fetch sees a fully written memory.
- Reset mid-load returns to LEN_HI at once. Memory keeps whatever words were already written. The next load restarts at word 0.
- `words_loaded` is 16 bits and N ≤ 65535, so it cannot wrap.

## Structure
- Shared defines file `loader_defs.vh`:
  - state encodings: LEN_HI, LEN_LO, DATA, FLUSH, DONE (3 bits).
  - `HDR_BYTES` = 2.
  - `BYTES_PER_WORD` = 4.
- One natural sub-module, `byte_word_packer`: byte counter plus 24-bit shift register. It outputs `word_complete` and the assembled 32-bit word.
- The FSM, word index and output registers stay in `imem_loader`.

## Test plan
- N=2; bytes 00 02, 20 08 00 05, 01 09 50 20:
  - `mem_we` pulses twice: addr 0 data 0x20080005, addr 1 data 0x01095020.
  - `cpu_reset` falls at the edge after the second pulse.
  - `done` = 1, `words_loaded` = 2.
- Same stream with `in_valid` low on alternate cycles → identical writes and values; byte gaps do not corrupt the word.
- N=0 (00 00) → no `mem_we`; `done` = 1 and `cpu_reset` = 0 on the edge after the second header byte; `in_ready` = 0 afterwards.
- ADDR_WIDTH=2, N=5:
  - `overflow` = 1 after the header.
  - Writes occur at addr 0..3 only; word 4 is consumed with no `mem_we`.
  - `words_loaded` = 5, `done` = 1.
- `reset` asserted after 6 data bytes of a 3-word load:
  - Outputs return to reset values immediately.
  - Restarting with a 1-word stream writes addr 0 with the new word.
- In DONE, drive `in_valid`=1 for 10 cycles → `in_ready` stays 0, no `mem_we`, all outputs stable.
